// File: rtl/cdc_afifo_wpacker.sv
// Byte-to-word packer feeding the write port of the async CDC FIFO (wclk domain).
// Bytes fill lanes little-endian; a full word or i_last closes it and it is pushed once the FIFO has room.

module cdc_afifo_wpacker_lane (
  input  logic       i_wclk,
  input  logic       i_nrst,
  input  logic       ld,
  input  logic       clr,
  input  logic [7:0] d,
  output logic [7:0] q,
  output logic       s
);
  always_ff @(posedge i_wclk or negedge i_nrst) begin
    if (!i_nrst) begin
      q <= '0;
      s <= 1'b0;
    end else if (clr) begin
      q <= '0;
      s <= 1'b0;
    end else if (ld) begin
      q <= d;
      s <= 1'b1;
    end
  end
endmodule

module cdc_afifo_wpacker #(
  parameter int dbits = 32
) (
  input  logic                 i_nrst,
  input  logic                 i_wclk,
  input  logic                 i_valid,
  input  logic [7:0]           i_data,
  input  logic                 i_last,
  output logic                 o_ready,
  input  logic                 i_wfull,
  output logic                 o_wr,
  output logic [dbits-1:0]     o_wdata,
  output logic [dbits/8-1:0]   o_wstrb,
  output logic                 o_wlast,
  output logic                 o_busy
);
  localparam int NBYTES = dbits / 8;
  localparam int CW     = $clog2(NBYTES) + 1;

  if ((dbits % 8) != 0 || dbits < 8) begin : g_bad_dbits
    $error("cdc_afifo_wpacker: dbits must be a multiple of 8 and >= 8");
  end

  typedef enum logic {FILL = 1'b0, PUSH = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt;
  logic [NBYTES-1:0][7:0]  data;
  logic [NBYTES-1:0]       strb;
  logic                    last;
  logic                    acc, close, wr_fire;

  assign acc     = (state == FILL) && i_valid;
  assign close   = acc && ((cnt == CW'(NBYTES - 1)) || i_last);
  assign wr_fire = (state == PUSH) && !i_wfull;

  always_ff @(posedge i_wclk or negedge i_nrst) begin
    if (!i_nrst) state <= FILL;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (close)    state_nxt = PUSH;
      PUSH: if (!i_wfull) state_nxt = FILL;
      default:            state_nxt = FILL;
    endcase
  end

  always_comb begin
    o_ready = (state == FILL) && i_nrst;
    o_wr    = wr_fire;
    o_wdata = data;
    o_wstrb = strb;
    o_wlast = last;
    o_busy  = (state == PUSH) || (cnt != '0);
  end

  // cnt stays on the closing lane until the push so o_busy remains high through PUSH
  always_ff @(posedge i_wclk or negedge i_nrst) begin
    if (!i_nrst) begin
      cnt  <= '0;
      last <= 1'b0;
    end else if (wr_fire) begin
      cnt  <= '0;
      last <= 1'b0;
    end else if (close) begin
      last <= i_last;
    end else if (acc) begin
      cnt  <= cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < NBYTES; k++) begin : g_lane
    cdc_afifo_wpacker_lane u_lane (
      .i_wclk (i_wclk),
      .i_nrst (i_nrst),
      .ld     (acc && (cnt == CW'(k))),
      .clr    (wr_fire),
      .d      (i_data),
      .q      (data[k]),
      .s      (strb[k])
    );
  end
endmodule

// File: tb/tb_cdc_afifo_wpacker.sv
// Directed + random stimulus for cdc_afifo_wpacker checked against a queue-based packet model.
module tb_cdc_afifo_wpacker;
  localparam int DB = 32;
  localparam int NB = DB / 8;

  typedef struct {
    logic [DB-1:0] d;
    logic [NB-1:0] s;
    logic          l;
  } word_t;

  logic          clk = 1'b0, nrst = 1'b0;
  logic          valid = 1'b0, last = 1'b0, wfull = 1'b0;
  logic [7:0]    data = '0;
  logic          ready, wr, wlast, busy;
  logic [DB-1:0] wdata;
  logic [NB-1:0] wstrb;

  int n_cmp = 0, n_bad = 0;

  cdc_afifo_wpacker #(.dbits(DB)) dut (
    .i_nrst (nrst),
    .i_wclk (clk),
    .i_valid(valid),
    .i_data (data),
    .i_last (last),
    .o_ready(ready),
    .i_wfull(wfull),
    .o_wr   (wr),
    .o_wdata(wdata),
    .o_wstrb(wstrb),
    .o_wlast(wlast),
    .o_busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: bytes collect into a partial packet; a full word or last byte makes a pending word,
  // which blocks input until the FIFO accepts it.
  word_t      exp_q[$];
  logic [7:0] part[$];
  word_t      mw;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      exp_q.delete();
      part.delete();
    end else if (exp_q.size() > 0) begin
      if (!wfull) void'(exp_q.pop_front());
    end else if (valid) begin
      part.push_back(data);
      if (part.size() == NB || last) begin
        mw.d = '0;
        mw.s = '0;
        for (int i = 0; i < part.size(); i++) begin
          mw.d[8*i +: 8] = part[i];
          mw.s[i]        = 1'b1;
        end
        mw.l = last;
        exp_q.push_back(mw);
        part.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (!nrst) begin
      chk("rst_ready", ready, 0);
      chk("rst_wr",    wr,    0);
      chk("rst_wdata", wdata, 0);
      chk("rst_wstrb", wstrb, 0);
      chk("rst_wlast", wlast, 0);
      chk("rst_busy",  busy,  0);
    end else begin
      chk("ready", ready, exp_q.size() == 0);
      chk("busy",  busy,  (exp_q.size() > 0) || (part.size() > 0));
      chk("wr",    wr,    (exp_q.size() > 0) && !wfull);
      if (wr && exp_q.size() > 0) begin
        chk("wdata", wdata, exp_q[0].d);
        chk("wstrb", wstrb, exp_q[0].s);
        chk("wlast", wlast, exp_q[0].l);
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic f);
    valid = v; data = d; last = l; wfull = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk();
    valid = 1'b0; last = 1'b0;
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("t_rst_wr", wr, 0);
    chk("t_rst_ready", ready, 0);
    nrst = 1'b1;
    #1;
    chk("t_ready_after_rst", ready, 1);
    chk("t_busy_after_rst", busy, 0);
    @(posedge clk); #1;

    // full word
    step(1, 8'h11, 0, 0); step(1, 8'h22, 0, 0); step(1, 8'h33, 0, 0); step(1, 8'h44, 0, 0);
    idle_chk();
    chk("t_full_wr", wr, 1);
    chk("t_full_wdata", wdata, 32'h44332211);
    chk("t_full_wstrb", wstrb, 4'b1111);
    chk("t_full_wlast", wlast, 0);
    chk("t_full_ready", ready, 0);
    step(0, 0, 0, 0);
    chk("t_full_ready_back", ready, 1);

    // partial flush
    step(1, 8'hAA, 0, 0); step(1, 8'hBB, 1, 0);
    idle_chk();
    chk("t_part_wr", wr, 1);
    chk("t_part_wdata", wdata, 32'h0000BBAA);
    chk("t_part_wstrb", wstrb, 4'b0011);
    chk("t_part_wlast", wlast, 1);
    step(0, 0, 0, 0);

    // backpressure
    step(1, 8'h01, 0, 1); step(1, 8'h02, 0, 1); step(1, 8'h03, 0, 1); step(1, 8'h04, 0, 1);
    for (int i = 0; i < 5; i++) begin
      idle_chk();
      chk("t_bp_wr", wr, 0);
      chk("t_bp_ready", ready, 0);
      chk("t_bp_wdata", wdata, 32'h04030201);
      step(0, 0, 0, 1);
    end
    wfull = 1'b0;
    #1;
    chk("t_bp_release_wr", wr, 1);
    step(0, 0, 0, 0);
    chk("t_bp_single_wr", wr, 0);

    // reset mid-word
    step(1, 8'hA1, 0, 0); step(1, 8'hA2, 0, 0);
    valid = 1'b0; nrst = 1'b0;
    #1;
    chk("t_mid_rst_busy", busy, 0);
    chk("t_mid_rst_wdata", wdata, 0);
    step(0, 0, 0, 0);
    nrst = 1'b1;
    step(0, 0, 0, 0);
    chk("t_mid_rst_no_wr", wr, 0);
    step(1, 8'hB1, 0, 0); step(1, 8'hB2, 0, 0); step(1, 8'hB3, 0, 0); step(1, 8'hB4, 0, 0);
    idle_chk();
    chk("t_mid_rst_wdata2", wdata, 32'hB4B3B2B1);
    chk("t_mid_rst_wstrb2", wstrb, 4'b1111);
    step(0, 0, 0, 0);

    // last on the final lane: single push
    step(1, 8'hC1, 0, 0); step(1, 8'hC2, 0, 0); step(1, 8'hC3, 0, 0); step(1, 8'hC4, 1, 0);
    idle_chk();
    chk("t_lastfull_wr", wr, 1);
    chk("t_lastfull_wstrb", wstrb, 4'b1111);
    chk("t_lastfull_wlast", wlast, 1);
    step(0, 0, 0, 0);
    chk("t_lastfull_once", wr, 0);

    // random stream with random backpressure; model checks every cycle
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) == 0);
    repeat (4) step(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
